// File: rtl/datapath_pkg.sv
// Shared scalar-pipe datapath types: register/word widths, FU ids and the
// writeback entry carried from functional units to the issue stage.
package datapath_pkg;
  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic {FU_ALU = 1'b0, FU_LDST = 1'b1} fu_scalar_t;

  localparam int WB_SRC_ALU  = 0;
  localparam int WB_SRC_LDST = 1;

  typedef struct packed {
    regbits_t rd;
    logic     wen;
    word_t    data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small per-source completion FIFO; head entry is visible on dout while
// non-empty. clear wins over push/pop in the same cycle.
module wb_fifo
  import datapath_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_entry_t
) (
  input  logic CLK,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  T     din,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               mem [DEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = mem[head];

  always_ff @(posedge CLK) begin
    if (do_push) mem[tail] <= din;
  end

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge CLK) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers scalar FU completions per source and grants one
// per cycle round-robin into a registered writeback packet.
module wb_arbiter
  import datapath_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC-1:0][4:0]            src_rd,
  input  logic [NUM_SRC-1:0]                 src_wen,
  input  logic [NUM_SRC-1:0][31:0]           src_data,
  input  logic                               flush,
  input  logic                               freeze,
  output logic                               wb_valid,
  output logic [$clog2(NUM_SRC)-1:0]         wb_src,
  output logic [4:0]                         wb_rd,
  output logic                               wb_wen,
  output logic [31:0]                        s_wdata
);
  localparam int SW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] full, empty, push, pop;
  wb_entry_t          head_q [NUM_SRC];
  logic [SW-1:0]      rr, win;
  logic               found, grant, clear;
  int                 idx;

  assign clear = RST || flush;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    wb_entry_t din;
    assign din          = '{rd: src_rd[i], wen: src_wen[i], data: src_data[i]};
    assign src_ready[i] = !full[i];
    assign push[i]      = src_valid[i] && !full[i];
    assign pop[i]       = grant && (win == SW'(i));

    wb_fifo #(.DEPTH(DEPTH), .T(wb_entry_t)) u_fifo (
      .CLK   (CLK),
      .clear (clear),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .dout  (head_q[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  // First non-empty source at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr) + k) % NUM_SRC;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
  end

  assign grant = found && !freeze && !clear;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr       <= '0;
      wb_valid <= 1'b0;
      wb_src   <= '0;
      wb_rd    <= '0;
      wb_wen   <= 1'b0;
      s_wdata  <= '0;
    end else if (flush) begin
      rr       <= '0;
      wb_valid <= 1'b0;
    end else if (grant) begin
      rr       <= SW'((int'(win) + 1) % NUM_SRC);
      wb_valid <= 1'b1;
      wb_src   <= win;
      wb_rd    <= head_q[win].rd;
      // x0 is hardwired; still report the completion so the FU clears.
      wb_wen   <= head_q[win].wen && (head_q[win].rd != '0);
      s_wdata  <= head_q[win].data;
    end else begin
      wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;
  logic            CLK = 1'b0;
  logic            RST;
  logic [1:0]      src_valid, src_ready, src_wen;
  logic [1:0][4:0] src_rd;
  logic [1:0][31:0] src_data;
  logic            flush, freeze;
  logic            wb_valid, wb_wen;
  logic [0:0]      wb_src;
  logic [4:0]      wb_rd;
  logic [31:0]     s_wdata;

  int tests = 0;
  int failed = 0;

  wb_arbiter #(.NUM_SRC(2), .DEPTH(2)) dut (
    .CLK(CLK), .RST(RST), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_wen(src_wen), .src_data(src_data),
    .flush(flush), .freeze(freeze), .wb_valid(wb_valid), .wb_src(wb_src),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .s_wdata(s_wdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [0:0] s, input logic [4:0] rd,
                        input logic wen, input logic [31:0] d);
    chk({tag, ".valid"}, 32'(wb_valid), 32'd1);
    chk({tag, ".src"},   32'(wb_src),   32'(s));
    chk({tag, ".rd"},    32'(wb_rd),    32'(rd));
    chk({tag, ".wen"},   32'(wb_wen),   32'(wen));
    chk({tag, ".data"},  s_wdata,       d);
  endtask

  task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d);
    src_rd[i]   = rd;
    src_data[i] = d;
  endtask

  int ia, ib, k;
  logic [1:0] rdy;

  initial begin
    RST = 1'b1; flush = 1'b0; freeze = 1'b0;
    src_valid = '0; src_wen = 2'b11; src_rd = '0; src_data = '0;
    tick(); tick();
    chk("rst.valid", 32'(wb_valid), 0);
    chk("rst.src",   32'(wb_src),   0);
    chk("rst.rd",    32'(wb_rd),    0);
    chk("rst.wen",   32'(wb_wen),   0);
    chk("rst.data",  s_wdata,       0);
    chk("rst.ready", 32'(src_ready), 32'h3);
    RST = 1'b0;

    // Single ALU completion: visible one cycle after the accepting edge.
    src_valid = 2'b01; set_src(0, 5'd5, 32'hDEADBEEF);
    tick();
    chk("single.pre", 32'(wb_valid), 0);
    src_valid = '0;
    tick();
    chk_wb("single", 1'b0, 5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    chk("single.post", 32'(wb_valid), 0);

    // Reset rr via flush, then both sources stream for 6 cycles.
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush0.valid", 32'(wb_valid), 0);
    ia = 0; ib = 0;
    for (int e = 1; e <= 9; e++) begin
      src_valid = (e <= 6) ? 2'b11 : 2'b00;
      set_src(0, 5'(1 + ia),  32'hA000_0000 + 32'(ia));
      set_src(1, 5'(10 + ib), 32'hB000_0000 + 32'(ib));
      rdy = src_ready;
      tick();
      if (e <= 6) begin
        if (rdy[0]) ia++;
        if (rdy[1]) ib++;
      end
      if (e == 1) chk("rr.first", 32'(wb_valid), 0);
      else begin
        k = (e - 2) / 2;
        if (e % 2 == 0) chk_wb($sformatf("rr.e%0d", e), 1'b0, 5'(1 + k),  1'b1, 32'hA000_0000 + 32'(k));
        else            chk_wb($sformatf("rr.e%0d", e), 1'b1, 5'(10 + k), 1'b1, 32'hB000_0000 + 32'(k));
      end
      if (e == 2) chk("rr.ready2", 32'(src_ready), 32'h1);
      if (e == 3) chk("rr.ready3", 32'(src_ready), 32'h2);
    end
    src_valid = '0;
    tick();
    chk("rr.drained", 32'(wb_valid), 0);
    chk("rr.acc_alu", 32'(ia), 4);
    chk("rr.acc_ldst", 32'(ib), 4);

    // LD/ST writing x0: completion still pulses, write enable suppressed.
    src_valid = 2'b10; set_src(1, 5'd0, 32'h1234_5678);
    tick(); src_valid = '0; tick();
    chk_wb("rd0", 1'b1, 5'd0, 1'b0, 32'h1234_5678);

    // One ALU grant leaves rr = 1 before the freeze test.
    src_valid = 2'b01; set_src(0, 5'd7, 32'hC0C0_0007);
    tick(); src_valid = '0; tick();
    chk_wb("pre_frz", 1'b0, 5'd7, 1'b1, 32'hC0C0_0007);

    freeze = 1'b1; src_valid = 2'b11;
    set_src(0, 5'd20, 32'hC000_0000); set_src(1, 5'd21, 32'hD000_0000);
    tick();
    chk("frz1.valid", 32'(wb_valid), 0);
    set_src(0, 5'd22, 32'hC000_0001); set_src(1, 5'd23, 32'hD000_0001);
    tick();
    chk("frz2.valid", 32'(wb_valid), 0);
    chk("frz2.ready", 32'(src_ready), 0);
    src_valid = '0;
    tick();
    chk("frz3.valid", 32'(wb_valid), 0);
    freeze = 1'b0;
    tick(); chk_wb("thaw0", 1'b1, 5'd21, 1'b1, 32'hD000_0000);
    chk("thaw0.ready", 32'(src_ready), 32'h2);
    tick(); chk_wb("thaw1", 1'b0, 5'd20, 1'b1, 32'hC000_0000);
    tick(); chk_wb("thaw2", 1'b1, 5'd23, 1'b1, 32'hD000_0001);
    tick(); chk_wb("thaw3", 1'b0, 5'd22, 1'b1, 32'hC000_0001);
    tick(); chk("thaw.idle", 32'(wb_valid), 0);

    // Two buffered entries, flush while ALU pushes: nothing survives.
    freeze = 1'b1; src_valid = 2'b11;
    set_src(0, 5'd3, 32'h0000_0333); set_src(1, 5'd4, 32'h0000_0444);
    tick();
    freeze = 1'b0; flush = 1'b1; src_valid = 2'b01;
    set_src(0, 5'd6, 32'h0000_0666);
    tick();
    chk("flush.valid", 32'(wb_valid), 0);
    chk("flush.ready", 32'(src_ready), 32'h3);
    chk("flush.hold_rd", 32'(wb_rd), 32'd22);
    flush = 1'b0; src_valid = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("flush.stale%0d", j), 32'(wb_valid), 0);
    end

    // Fill both FIFOs, then reset mid-stream.
    freeze = 1'b1; src_valid = 2'b11;
    set_src(0, 5'd9, 32'h9999_0000); set_src(1, 5'd8, 32'h8888_0000);
    tick(); tick();
    chk("full.ready", 32'(src_ready), 0);
    freeze = 1'b0; RST = 1'b1;
    tick();
    chk("rst2.valid", 32'(wb_valid), 0);
    chk("rst2.src",   32'(wb_src),   0);
    chk("rst2.rd",    32'(wb_rd),    0);
    chk("rst2.wen",   32'(wb_wen),   0);
    chk("rst2.data",  s_wdata,       0);
    chk("rst2.ready", 32'(src_ready), 32'h3);
    RST = 1'b0; src_valid = '0;
    tick(); chk("rst2.idle0", 32'(wb_valid), 0);
    tick(); chk("rst2.idle1", 32'(wb_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
